instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Buffers 64-bit host instructions in a FIFO and issues them one at a time to the systolic-array instruction decoder.
- Opcode is in bits [4:0]. Write-type opcodes issue back-to-back, one per cycle.
- Streaming opcodes (MAC, send weights) hold off further issue until the array signals stream completion.
- Sits between the host interface and the instruction decoder; owns instruction ordering and flow control.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- PTR_W, 4, log2(DEPTH).
- TIMEOUT, 1024, max cycles to wait for stream_done (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- host_instr  in  64  instruction from host.
- host_valid  in  1  host_instr valid.
- host_ready  out  1  FIFO can accept; equals !full.
- flush  in  1  synchronous clear of FIFO and FSM.
- instr_out  out  64  instruction to decoder; 64'b0 means "no instruction".
- stream_done  in  1  single-cycle pulse from array: current stream finished.
- busy  out  1  high when FIFO is non-empty or FSM is not IDLE.
- fifo_count  out  PTR_W+1  current FIFO occupancy.
- bad_opcode  out  1  sticky; set when an undefined opcode is dropped.
- timeout_err  out  1  sticky; set on stream timeout (optional feature only, else tied 0).

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied; state = IDLE.
  - instr_out = 0, host_ready = 1, busy = 0, fifo_count = 0, bad_opcode = 0, timeout_err = 0.
  - Reset mid-stream discards all pending and in-flight instructions.
- Push: host_valid && host_ready at a rising edge writes host_instr at wr_ptr.
  - Pointers wrap modulo DEPTH; full/empty determined from fifo_count.
  - When full, host_ready = 0 even if a pop occurs in the same cycle.
- Opcode classes:
  - 00000 and 11111: popped and discarded; instr_out stays 0; no cycle consumed beyond the pop.
  - 00001 (MAC) and 00010 (send weights): streaming.
  - 00011 to 00111: write-type.
  - All other opcodes: dropped, bad_opcode set; not issued.
- FSM states: IDLE, WAIT_STREAM.
  - IDLE, FIFO non-empty:
    - Pop head; register it onto instr_out for exactly one cycle.
    - Write-type: stay in IDLE; next head may issue the following cycle (1 instruction/cycle throughput).
    - Streaming: go to WAIT_STREAM.
  - IDLE, FIFO empty: instr_out = 0.
  - WAIT_STREAM:
    - instr_out = 0; no pops.
    - On stream_done = 1, return to IDLE. The next issue appears on instr_out at the edge after the one that samples stream_done.
    - A stream_done pulse arriving in IDLE is ignored.
- Latency: with FIFO empty and state IDLE, an instruction pushed at edge E appears on instr_out after edge E+1 and is held for one cycle.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - flush has priority over push, pop and stream_done. On the next edge: FIFO emptied, state IDLE, instr_out 0. Sticky flags are kept.
- The decoder samples instr_out each cycle, so instr_out must never repeat an instruction on consecutive cycles unless the FIFO contains duplicates.

Optional Feature:
- Macro: STREAM_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on entry to WAIT_STREAM.
  - If it reaches TIMEOUT-1 without stream_done: set timeout_err (sticky), return to IDLE, resume issuing.
- Undefined:
  - WAIT_STREAM waits indefinitely; no counter is instantiated; timeout_err is tied 0.

Test Plan:
- Push 3 write-type instructions (opcodes 00100, 00101, 00011) on consecutive cycles → instr_out shows each for one cycle on 3 consecutive cycles starting 1 cycle after the first push; then returns to 0 and busy = 0.
- Push MAC (00001), then 00100 → MAC issued; instr_out = 0 while waiting; stream_done pulsed 10 cycles later → 00100 issued on the next cycle.
- Push 16 entries with the FSM held in WAIT_STREAM → host_ready = 0 and fifo_count = 16; a 17th push is not accepted. Pulse stream_done → entries drain in order, host_ready rises after the first pop.
- Push opcode 01010, then 11111, then 00111 → bad_opcode = 1; only 00111 appears on instr_out.
- Assert rst_n low during WAIT_STREAM with 5 entries queued → all outputs return to reset values immediately; no queued instruction issues after reset.
- With STREAM_TIMEOUT_EN and TIMEOUT = 8: issue 00010 with no stream_done → timeout_err = 1 after 8 cycles, then the next queued instruction issues.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers 64-bit host instructions in a FIFO and issues them
// one per cycle to the systolic-array instruction decoder. Write-type opcodes
// issue back-to-back; streaming opcodes (MAC, send weights) block further
// issue until the array pulses stream_done.
// Optional feature: define STREAM_TIMEOUT_EN to give up waiting for
// stream_done after TIMEOUT cycles, raising the sticky timeout_err flag.
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      host_instr,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic             flush,
    output logic [63:0]      instr_out,
    input  logic             stream_done,
    output logic             busy,
    output logic [PTR_W:0]   fifo_count,
    output logic             bad_opcode,
    output logic             timeout_err
);

    typedef enum logic {
        IDLE,
        WAIT_STREAM
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [63:0]    fifo_mem [DEPTH];

    state_t         state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] count_q, count_d;
    logic [63:0]    instr_out_q, instr_out_d;
    logic           bad_q, bad_d;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [63:0]    head;
    logic [4:0]     head_op;
    logic           op_stream;
    logic           op_write;
    logic           op_discard;

`ifdef STREAM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             terr_q, terr_d;
`else
    // TIMEOUT only matters when the stream timeout is built in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // FIFO status, head-of-queue decode and the push/pop handshakes.
    always_comb begin
        full       = (count_q == FULL_CNT);
        empty      = (count_q == '0);
        head       = fifo_mem[rd_ptr_q];
        head_op    = head[4:0];
        push       = host_valid && !full;
        pop        = (state_q == IDLE) && !empty;
        op_stream  = 1'b0;
        op_write   = 1'b0;
        op_discard = 1'b0;
        case (head_op)
            5'd0, 5'd31:                    op_discard = 1'b1;
            5'd1, 5'd2:                     op_stream  = 1'b1;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7:   op_write   = 1'b1;
            default:                        ;
        endcase
    end

    // Next-state logic: flush wins over everything, otherwise pop/issue,
    // stream wait handling and push all update in parallel.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        instr_out_d = '0;
        bad_d       = bad_q;
`ifdef STREAM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        terr_d      = terr_q;
`endif
        if (flush) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (op_stream) begin
                    instr_out_d = head;
                    state_d     = WAIT_STREAM;
`ifdef STREAM_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end else if (op_write) begin
                    instr_out_d = head;
                end else if (!op_discard) begin
                    bad_d = 1'b1;
                end
            end
            if (state_q == WAIT_STREAM) begin
                if (stream_done) begin
                    state_d = IDLE;
`ifdef STREAM_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
`endif
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            instr_out_q <= '0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            instr_out_q <= instr_out_d;
            bad_q       <= bad_d;
        end
    end

`ifdef STREAM_TIMEOUT_EN
    // Stream timeout counter and its sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            terr_q    <= terr_d;
        end
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_mem[wr_ptr_q] <= host_instr;
        end
    end

    assign host_ready = !full;
    assign busy       = !empty || (state_q != IDLE);
    assign fifo_count = count_q;
    assign instr_out  = instr_out_q;
    assign bad_opcode = bad_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: hand-computed vector table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam int TMO   = 8;

`ifdef STREAM_TIMEOUT_EN
    localparam int MAC_WAIT = 5;
`else
    localparam int MAC_WAIT = 10;
`endif

    localparam logic [63:0] W1  = 64'h1111_0000_0000_0004;
    localparam logic [63:0] W2  = 64'h2222_0000_0000_0005;
    localparam logic [63:0] W3  = 64'h3333_0000_0000_0003;
    localparam logic [63:0] BO  = 64'h4444_0000_0000_000A;
    localparam logic [63:0] DO  = 64'h5555_0000_0000_001F;
    localparam logic [63:0] W7  = 64'h6666_0000_0000_0007;
    localparam logic [63:0] MAC = 64'h7777_0000_0000_0001;
    localparam logic [63:0] W4  = 64'h8888_0000_0000_0004;
    localparam logic [63:0] SW  = 64'hABCD_0000_0000_0002;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [63:0]      host_instr;
    logic             host_valid;
    logic             host_ready;
    logic             flush;
    logic [63:0]      instr_out;
    logic             stream_done;
    logic             busy;
    logic [PTR_W:0]   fifo_count;
    logic             bad_opcode;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending instructions in arrival order, whether a
    // stream is outstanding, what the decoder should see, and sticky flags.
    logic [63:0] mq[$];
    bit          m_wait;
    logic [63:0] m_out;
    bit          m_bad;
    bit          m_terr;
    int          m_elapsed;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        sd;
        logic        fl;
        logic [63:0] want_out;
        int          want_cnt;
        logic        want_busy;
        logic        want_bad;
    } vec_t;

    vec_t tbl[10];
    logic [63:0] fill_data[DEPTH];

    instr_sequencer #(
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_instr  (host_instr),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .flush       (flush),
        .instr_out   (instr_out),
        .stream_done (stream_done),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .bad_opcode  (bad_opcode),
        .timeout_err (timeout_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_wait    = 1'b0;
        m_out     = '0;
        m_bad     = 1'b0;
        m_terr    = 1'b0;
        m_elapsed = 0;
    endtask

    // One clock edge of the specified behaviour, using pre-edge state.
    task automatic modelStep(input bit v, input logic [63:0] d, input bit sd, input bit fl);
        int          pre_size;
        bit          pre_wait;
        logic [63:0] hd;
        int          op;
        pre_size = mq.size();
        pre_wait = m_wait;
        m_out    = '0;
        if (fl) begin
            mq.delete();
            m_wait = 1'b0;
            return;
        end
        if (pre_wait) begin
            if (sd) begin
                m_wait = 1'b0;
            end else begin
`ifdef STREAM_TIMEOUT_EN
                if (m_elapsed == TMO - 1) begin
                    m_wait = 1'b0;
                    m_terr = 1'b1;
                end else begin
                    m_elapsed++;
                end
`endif
            end
        end else if (pre_size > 0) begin
            hd = mq.pop_front();
            op = int'(hd[4:0]);
            if (op == 1 || op == 2) begin
                m_out     = hd;
                m_wait    = 1'b1;
                m_elapsed = 0;
            end else if (op >= 3 && op <= 7) begin
                m_out = hd;
            end else if (op != 0 && op != 31) begin
                m_bad = 1'b1;
            end
        end
        if (v && pre_size < DEPTH) begin
            mq.push_back(d);
        end
    endtask

    task automatic compareModel();
        checkOutput("instr_out", instr_out, m_out);
        checkOutput("fifo_count", 64'(fifo_count), 64'(mq.size()));
        checkOutput("host_ready", 64'(host_ready), (mq.size() < DEPTH) ? 64'd1 : 64'd0);
        checkOutput("busy", 64'(busy), (mq.size() != 0 || m_wait) ? 64'd1 : 64'd0);
        checkOutput("bad_opcode", 64'(bad_opcode), 64'(m_bad));
        checkOutput("timeout_err", 64'(timeout_err), 64'(m_terr));
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare.
    task automatic applyStimulus(input bit v, input logic [63:0] d, input bit sd, input bit fl);
        host_valid  = v;
        host_instr  = d;
        stream_done = sd;
        flush       = fl;
        @(posedge clk);
        modelStep(v, d, sd, fl);
        #1;
        compareModel();
        host_valid  = 1'b0;
        host_instr  = '0;
        stream_done = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " instr_out"}, instr_out, 64'd0);
        checkOutput({tag, " host_ready"}, 64'(host_ready), 64'd1);
        checkOutput({tag, " busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " fifo_count"}, 64'(fifo_count), 64'd0);
        checkOutput({tag, " bad_opcode"}, 64'(bad_opcode), 64'd0);
        checkOutput({tag, " timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    initial begin
        logic [63:0] rd;
        int          r;
        bit          rv;
        bit          rs;
        bit          rf;

        // Vector table: inputs for one cycle and the outputs after its edge.
        tbl[0] = '{1'b1, W1, 1'b0, 1'b0, 64'd0, 1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, W2, 1'b0, 1'b0, W1,    1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, W3, 1'b0, 1'b0, W2,    1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 64'd0, 1'b0, 1'b0, W3, 0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, BO, 1'b0, 1'b0, 64'd0, 1, 1'b1, 1'b0};
        tbl[6] = '{1'b1, DO, 1'b0, 1'b0, 64'd0, 1, 1'b1, 1'b1};
        tbl[7] = '{1'b1, W7, 1'b0, 1'b0, 64'd0, 1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 64'd0, 1'b0, 1'b0, W7, 0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 0, 1'b0, 1'b1};

        for (int i = 0; i < DEPTH; i++) begin
            fill_data[i] = {8'hF0, 24'(i), 27'd0, 5'(3 + (i % 5))};
        end

        rst_n       = 1'b0;
        host_valid  = 1'b0;
        host_instr  = '0;
        stream_done = 1'b0;
        flush       = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;

        // Table: write-type back-to-back issue, then undefined/discard opcodes.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].sd, tbl[i].fl);
            checkOutput($sformatf("tbl[%0d] instr_out", i), instr_out, tbl[i].want_out);
            checkOutput($sformatf("tbl[%0d] fifo_count", i), 64'(fifo_count), 64'(tbl[i].want_cnt));
            checkOutput($sformatf("tbl[%0d] busy", i), 64'(busy), 64'(tbl[i].want_busy));
            checkOutput($sformatf("tbl[%0d] bad_opcode", i), 64'(bad_opcode), 64'(tbl[i].want_bad));
        end

        // MAC holds off the following write until stream_done.
        applyStimulus(1'b1, MAC, 1'b0, 1'b0);
        applyStimulus(1'b1, W4, 1'b0, 1'b0);
        checkOutput("mac issue", instr_out, MAC);
        for (int i = 0; i < MAC_WAIT - 1; i++) begin
            idleCycle();
            checkOutput("mac wait instr_out", instr_out, 64'd0);
            checkOutput("mac wait busy", 64'(busy), 64'd1);
        end
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("mac done instr_out", instr_out, 64'd0);
        idleCycle();
        checkOutput("after mac instr_out", instr_out, W4);
        idleCycle();
        checkOutput("after mac idle", instr_out, 64'd0);
        checkOutput("after mac busy", 64'(busy), 64'd0);

`ifndef STREAM_TIMEOUT_EN
        // Fill the FIFO while a stream is outstanding, then drain in order.
        applyStimulus(1'b1, MAC, 1'b0, 1'b0);
        idleCycle();
        checkOutput("fill mac issue", instr_out, MAC);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, fill_data[i], 1'b0, 1'b0);
        end
        checkOutput("full host_ready", 64'(host_ready), 64'd0);
        checkOutput("full fifo_count", 64'(fifo_count), 64'd16);
        applyStimulus(1'b1, 64'hDEAD_0000_0000_0003, 1'b0, 1'b0);
        checkOutput("17th push count", 64'(fifo_count), 64'd16);
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("full done count", 64'(fifo_count), 64'd16);
        for (int i = 0; i < DEPTH; i++) begin
            idleCycle();
            checkOutput($sformatf("drain[%0d]", i), instr_out, fill_data[i]);
            if (i == 0) begin
                checkOutput("drain host_ready", 64'(host_ready), 64'd1);
                checkOutput("drain fifo_count", 64'(fifo_count), 64'd15);
            end
        end
        idleCycle();
        checkOutput("drained instr_out", instr_out, 64'd0);
`endif

        // Flush beats simultaneous push and stream_done; sticky flag kept.
        applyStimulus(1'b1, 64'h9999_0000_0000_0003, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h9999_0000_0000_0006, 1'b0, 1'b0);
        checkOutput("pre-flush issue", instr_out, 64'h9999_0000_0000_0003);
        applyStimulus(1'b1, 64'h9999_0000_0000_0005, 1'b1, 1'b1);
        checkOutput("flush instr_out", instr_out, 64'd0);
        checkOutput("flush fifo_count", 64'(fifo_count), 64'd0);
        checkOutput("flush busy", 64'(busy), 64'd0);
        checkOutput("flush keeps bad", 64'(bad_opcode), 64'd1);
        idleCycle();
        checkOutput("post-flush instr_out", instr_out, 64'd0);

        // Flush while waiting on a stream returns to IDLE.
        applyStimulus(1'b1, MAC, 1'b0, 1'b0);
        applyStimulus(1'b1, W2, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
        checkOutput("wait flush busy", 64'(busy), 64'd0);
        applyStimulus(1'b1, W3, 1'b0, 1'b0);
        idleCycle();
        checkOutput("wait flush resume", instr_out, W3);

        // Asynchronous reset mid-stream discards queued work.
        applyStimulus(1'b1, MAC, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, fill_data[i], 1'b0, 1'b0);
        end
        checkOutput("pre-reset fifo_count", 64'(fifo_count), 64'd5);
        rst_n = 1'b0;
        #1;
        checkResetValues("async reset");
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idleCycle();
            checkOutput("post-reset instr_out", instr_out, 64'd0);
        end

`ifdef STREAM_TIMEOUT_EN
        // Send-weights with no stream_done times out after TMO cycles.
        applyStimulus(1'b1, SW, 1'b0, 1'b0);
        applyStimulus(1'b1, W2, 1'b0, 1'b0);
        checkOutput("tmo issue", instr_out, SW);
        for (int i = 0; i < TMO - 1; i++) begin
            idleCycle();
            checkOutput("tmo pending err", 64'(timeout_err), 64'd0);
        end
        idleCycle();
        checkOutput("tmo err set", 64'(timeout_err), 64'd1);
        checkOutput("tmo instr_out", instr_out, 64'd0);
        idleCycle();
        checkOutput("tmo resume", instr_out, W2);
`else
        // Without the timeout a stream waits for stream_done indefinitely.
        applyStimulus(1'b1, SW, 1'b0, 1'b0);
        applyStimulus(1'b1, W2, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            idleCycle();
        end
        checkOutput("no-tmo still waiting", 64'(busy), 64'd1);
        checkOutput("no-tmo err", 64'(timeout_err), 64'd0);
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        idleCycle();
        checkOutput("no-tmo resume", instr_out, W2);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r  = int'($urandom_range(0, 9));
            rd = {$urandom, $urandom};
            if (r <= 4) begin
                rd[4:0] = 5'(3 + $urandom_range(0, 4));
            end else if (r <= 6) begin
                rd[4:0] = 5'(1 + $urandom_range(0, 1));
            end else if (r == 7) begin
                rd[4:0] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
            end else begin
                rd[4:0] = 5'($urandom_range(8, 30));
            end
            rv = ($urandom_range(0, 99) < 70);
            rs = ($urandom_range(0, 99) < 15);
            rf = ($urandom_range(0, 99) < 2);
            applyStimulus(rv, rd, rs, rf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
